// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared K&S decoded-opcode type used by the decoder and control unit
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

// File: rtl/ks_control_unit_mc_if.sv
// ks_control_unit_mc_if: flag/debug inputs and datapath enables of the K&S control unit
// master: control unit side (samples flags/step/resume, drives enables, halt, instr_done)
// slave : datapath/debug side
interface ks_control_unit_mc_if;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow, step, resume;
  logic branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel;
  logic flags_reg_enable, ram_write_enable, halt, instr_done;
  logic [1:0] operation;
  modport master (
    input  zero_op, neg_op, unsigned_overflow, signed_overflow, step, resume,
    output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
           flags_reg_enable, ram_write_enable, halt, instr_done, operation
  );
  modport slave (
    output zero_op, neg_op, unsigned_overflow, signed_overflow, step, resume,
    input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
           flags_reg_enable, ram_write_enable, halt, instr_done, operation
  );
endinterface

// File: rtl/ks_control_unit_mc.sv
// ks_control_unit_mc: multi-cycle K&S control FSM with fetch/memory wait states and single-step
// Ports: clk, rst (async, active-high), decoded_instruction (current opcode),
//        bus (flags, step, resume in; datapath enables, operation, halt, instr_done out),
//        instr_count (only with KS_PERF_CNT_EN defined: completed-instruction counter).
module ks_control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int unsigned FETCH_WAIT = 0,
  parameter int unsigned MEM_WAIT   = 0,
  parameter bit          OV_SIGNED  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
`ifdef KS_PERF_CNT_EN
  output logic [31:0]             instr_count,
`endif
  ks_control_unit_mc_if.master    bus
);
  typedef enum logic [2:0] {FETCH, LOAD_IR, DECODE, EXEC, MEM, MEM_WB, HALTED} state_t;
  state_t state, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic cmp, take, ovf;
  logic [1:0] alu_op;
  always_comb begin
    ovf = OV_SIGNED ? bus.signed_overflow : bus.unsigned_overflow;
    alu_op = (decoded_instruction == I_AND) ? 2'b01 :
             (decoded_instruction == I_SUB) ? 2'b11 :
             (decoded_instruction inside {I_OR, I_MOVE}) ? 2'b10 : 2'b00;
    take = (decoded_instruction == I_BRANCH) ||
           (decoded_instruction == I_BZERO  &&  bus.zero_op) ||
           (decoded_instruction == I_BNZERO && !bus.zero_op) ||
           (decoded_instruction == I_BNEG   &&  bus.neg_op) ||
           (decoded_instruction == I_BNNEG  && !bus.neg_op) ||
           (decoded_instruction == I_BOV    &&  ovf) ||
           (decoded_instruction == I_BNOV   && !ovf);
    nxt = state;
    cnt_nxt = cnt;
    cmp = 1'b0;
    bus.branch = 1'b0;
    bus.pc_enable = 1'b0;
    bus.ir_enable = 1'b0;
    bus.write_reg_enable = 1'b0;
    bus.addr_sel = 1'b0;
    bus.c_sel = 1'b0;
    bus.flags_reg_enable = 1'b0;
    bus.ram_write_enable = 1'b0;
    bus.operation = 2'b00;
    bus.halt = 1'b0;
    case (state)
      FETCH: if (cnt != '0) cnt_nxt = cnt - 1'b1; else nxt = LOAD_IR;
      LOAD_IR: begin
        bus.ir_enable = 1'b1;
        bus.pc_enable = 1'b1;
        nxt = DECODE;
      end
      DECODE: case (decoded_instruction)
        I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
          bus.operation = alu_op;
          nxt = EXEC;
        end
        I_LOAD, I_STORE: begin
          bus.addr_sel = 1'b1;
          nxt = MEM;
        end
        I_HALT: nxt = HALTED;
        // branches and unknown opcodes both finish here; take is 0 for non-branches
        default: begin
          bus.branch = take;
          bus.pc_enable = take;
          cmp = 1'b1;
        end
      endcase
      EXEC: begin
        bus.write_reg_enable = 1'b1;
        bus.operation = alu_op;
        bus.flags_reg_enable = decoded_instruction != I_MOVE;
        cmp = 1'b1;
      end
      MEM: begin
        bus.addr_sel = 1'b1;
        bus.c_sel = decoded_instruction == I_LOAD;
        if (cnt != '0) cnt_nxt = cnt - 1'b1; else nxt = MEM_WB;
      end
      MEM_WB: begin
        bus.addr_sel = decoded_instruction inside {I_LOAD, I_STORE};
        bus.c_sel = decoded_instruction == I_LOAD;
        bus.write_reg_enable = decoded_instruction == I_LOAD;
        bus.ram_write_enable = decoded_instruction == I_STORE;
        cmp = 1'b1;
      end
      HALTED: begin
        bus.halt = 1'b1;
        if (bus.resume) nxt = FETCH;
      end
      default: nxt = FETCH;
    endcase
    if (cmp) nxt = bus.step ? HALTED : FETCH;
    // the wait counter is armed on entry to FETCH/MEM; after reset it is 0, so the first fetch is one cycle
    if (nxt != state) cnt_nxt = (nxt == FETCH) ? 4'(FETCH_WAIT) : (nxt == MEM) ? 4'(MEM_WAIT) : cnt;
    bus.instr_done = cmp || (state == DECODE && decoded_instruction == I_HALT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  end
`ifdef KS_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instr_count <= '0;
    else if (bus.instr_done) instr_count <= instr_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_ks_control_unit_mc.sv
// tb_ks_control_unit_mc: scoreboard bench for ks_control_unit_mc (two parameter sets)
module tb_ks_control_unit_mc;
  import k_and_s_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  decoded_instruction_type da, db;
  ks_control_unit_mc_if ia ();
  ks_control_unit_mc_if ib ();
`ifdef KS_PERF_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif
  ks_control_unit_mc #(.FETCH_WAIT(0), .MEM_WAIT(2), .OV_SIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .decoded_instruction(da),
`ifdef KS_PERF_CNT_EN
    .instr_count(cnt_a),
`endif
    .bus(ia)
  );
  ks_control_unit_mc #(.FETCH_WAIT(1), .MEM_WAIT(3), .OV_SIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .decoded_instruction(db),
`ifdef KS_PERF_CNT_EN
    .instr_count(cnt_b),
`endif
    .bus(ib)
  );
  typedef struct packed {
    logic branch, pc, ir, wre, addr, c, flags, ram;
    logic [1:0] op;
    logic halt, done;
  } ov_t;
  typedef struct {
    ov_t v;
    string tag;
  } item_t;
  ov_t obs_a, obs_b, obs;
  logic sel = 1'b0;
  assign obs_a = {ia.branch, ia.pc_enable, ia.ir_enable, ia.write_reg_enable, ia.addr_sel, ia.c_sel,
                  ia.flags_reg_enable, ia.ram_write_enable, ia.operation, ia.halt, ia.instr_done};
  assign obs_b = {ib.branch, ib.pc_enable, ib.ir_enable, ib.write_reg_enable, ib.addr_sel, ib.c_sel,
                  ib.flags_reg_enable, ib.ram_write_enable, ib.operation, ib.halt, ib.instr_done};
  assign obs = sel ? obs_b : obs_a;
  item_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  task automatic push(input string tag, input ov_t v);
    item_t e;
    e.v = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask
  task automatic model(input decoded_instruction_type d, input logic z, n, uo, so, input int fw, mw, input bit ovs);
    ov_t v;
    logic ovf, tk;
    for (int i = 0; i < 1 + fw; i++) push("fetch", '0);
    v = '0; v.ir = 1'b1; v.pc = 1'b1;
    push("load_ir", v);
    v = '0;
    case (d)
      I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
        v.op = (d == I_ADD) ? 2'b00 : (d == I_AND) ? 2'b01 : (d == I_SUB) ? 2'b11 : 2'b10;
        push("decode_alu", v);
        v.wre = 1'b1; v.flags = (d != I_MOVE); v.done = 1'b1;
        push("exec", v);
      end
      I_LOAD, I_STORE: begin
        v.addr = 1'b1;
        push("decode_mem", v);
        v.c = (d == I_LOAD);
        for (int i = 0; i < 1 + mw; i++) push("mem", v);
        v.done = 1'b1;
        if (d == I_LOAD) v.wre = 1'b1; else v.ram = 1'b1;
        push("mem_wb", v);
      end
      default: begin
        ovf = ovs ? so : uo;
        tk = (d == I_BRANCH) || (d == I_BZERO && z) || (d == I_BNZERO && !z) || (d == I_BNEG && n) ||
             (d == I_BNNEG && !n) || (d == I_BOV && ovf) || (d == I_BNOV && !ovf);
        v.branch = tk; v.pc = tk; v.done = 1'b1;
        push("decode_br", v);
      end
    endcase
  endtask
  task automatic drain(input int k);
    item_t e;
    for (int i = 0; i < k && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      compared++;
      if (obs !== e.v) begin
        mismatched++;
        $display("FAIL %s @%0t: got %b expected %b", e.tag, $time, obs, e.v);
      end
    end
  endtask
  task automatic run(input bit s, input bit first, input int fw, input decoded_instruction_type d,
                     input logic z, n, uo, so, st);
    if (!first) begin
      @(posedge clk);
      #1;
    end
    sel = s;
    if (s) begin
      db = d; ib.zero_op = z; ib.neg_op = n; ib.unsigned_overflow = uo; ib.signed_overflow = so; ib.step = st;
    end else begin
      da = d; ia.zero_op = z; ia.neg_op = n; ia.unsigned_overflow = uo; ia.signed_overflow = so; ia.step = st;
    end
    model(d, z, n, uo, so, fw, s ? 3 : 2, !s);
    drain(1000);
  endtask
  task automatic halted(input int k);
    ov_t v;
    v = '0; v.halt = 1'b1;
    for (int i = 0; i < k; i++) push("halted", v);
    drain(k);
  endtask
  task automatic do_resume(input bit s, input logic st);
    @(posedge clk);
    #1;
    if (s) begin ib.resume = 1'b1; ib.step = st; end else begin ia.resume = 1'b1; ia.step = st; end
    halted(1);
    @(posedge clk);
    #1;
    if (s) ib.resume = 1'b0; else ia.resume = 1'b0;
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    compared += 2;
    if (obs_a !== '0) begin mismatched++; $display("FAIL reset_a: got %b expected 0", obs_a); end
    if (obs_b !== '0) begin mismatched++; $display("FAIL reset_b: got %b expected 0", obs_b); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_alu();
    run(0, 1, 0, I_ADD, 0, 0, 0, 0, 0);
    run(0, 0, 0, I_SUB, 1, 0, 0, 0, 0);
    run(0, 0, 0, I_AND, 0, 1, 0, 0, 0);
    run(0, 0, 0, I_OR,  0, 0, 1, 1, 0);
    run(0, 0, 0, I_MOVE, 0, 0, 0, 0, 0);
  endtask
  task automatic test_mem();
    run(0, 0, 0, I_LOAD, 0, 0, 0, 0, 0);
    run(0, 0, 0, I_STORE, 0, 0, 0, 0, 0);
  endtask
  task automatic test_branch();
    run(0, 0, 0, I_BOV,    0, 0, 0, 1, 0);
    run(0, 0, 0, I_BNOV,   0, 0, 0, 1, 0);
    run(0, 0, 0, I_BOV,    0, 0, 1, 0, 0);
    run(0, 0, 0, I_BZERO,  1, 0, 0, 0, 0);
    run(0, 0, 0, I_BNZERO, 1, 0, 0, 0, 0);
    run(0, 0, 0, I_BNEG,   0, 1, 0, 0, 0);
    run(0, 0, 0, I_BNNEG,  0, 0, 0, 0, 0);
    run(0, 0, 0, I_BRANCH, 0, 0, 0, 0, 0);
    run(0, 0, 0, I_NOP,    0, 0, 0, 0, 0);
  endtask
  task automatic test_step();
    run(0, 0, 0, I_MOVE, 0, 0, 0, 0, 1);
    halted(3);
    do_resume(0, 1);
    run(0, 1, 0, I_ADD, 0, 0, 0, 0, 1);
    halted(2);
    do_resume(0, 0);
    run(0, 1, 0, I_HALT, 0, 0, 0, 0, 0);
    halted(100);
    do_resume(0, 0);
    run(0, 1, 0, I_SUB, 0, 0, 0, 0, 0);
  endtask
  task automatic test_params_b();
    pulse_reset();
    run(1, 1, 0, I_ADD, 0, 0, 0, 0, 0);
    run(1, 0, 1, I_BOV,  0, 0, 0, 1, 0);
    run(1, 0, 1, I_BNOV, 0, 0, 0, 1, 0);
    run(1, 0, 1, I_LOAD, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset_abort();
    @(posedge clk);
    #1;
    sel = 1'b1;
    db = I_STORE; ib.step = 1'b0;
    model(I_STORE, 0, 0, 0, 0, 1, 3, 1'b0);
    drain(7);
    exp_q.delete();
    #1 rst = 1'b1;
    #1;
    compared++;
    if (obs_b !== '0) begin mismatched++; $display("FAIL abort_immediate: got %b expected 0", obs_b); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (obs_b !== '0) begin mismatched++; $display("FAIL abort_held: got %b expected 0", obs_b); end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    run(1, 1, 0, I_NOP, 0, 0, 0, 0, 0);
    run(1, 0, 1, I_ADD, 0, 0, 0, 0, 0);
  endtask
`ifdef KS_PERF_CNT_EN
  task automatic test_perf();
    decoded_instruction_type mix [10];
    mix = '{I_ADD, I_LOAD, I_BOV, I_STORE, I_MOVE, I_NOP, I_SUB, I_BRANCH, I_OR, I_AND};
    pulse_reset();
    for (int i = 0; i < 10; i++) run(0, i == 0, 0, mix[i], 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    compared++;
    if (cnt_a !== 32'd10) begin mismatched++; $display("FAIL perf_count: got %0d expected 10", cnt_a); end
    force dut_a.instr_count = 32'hFFFF_FFFF;
    #1 release dut_a.instr_count;
    run(0, 1, 0, I_ADD, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    compared++;
    if (cnt_a !== 32'd0) begin mismatched++; $display("FAIL perf_wrap: got %h expected 0", cnt_a); end
  endtask
`endif
  initial begin
    da = I_NOP; db = I_NOP;
    {ia.zero_op, ia.neg_op, ia.unsigned_overflow, ia.signed_overflow, ia.step, ia.resume} = '0;
    {ib.zero_op, ib.neg_op, ib.unsigned_overflow, ib.signed_overflow, ib.step, ib.resume} = '0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_step();
    test_params_b();
    test_reset_abort();
`ifdef KS_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
